// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM states,
// requester ownership and the latched request-bus payload.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WEN_W      = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned MEM_BUS_WD = 1 + WEN_W + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_e;

  typedef struct packed {
    logic              req;
    logic [WEN_W-1:0]  wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_bus_req_t;

endpackage

// File: rtl/mem_grant_sel.sv
// Priority select between the two requesters: data wins unless inst has
// waited through STARVE_LIMIT consecutive data grants.
module mem_grant_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   arb_en_i,
  input  logic   inst_req_i,
  input  logic   data_req_i,
  output logic   grant_vld_c_o,
  output owner_e grant_own_c_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             inst_starved;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    grant_vld_c_o = 1'b0;
    grant_own_c_o = INST;
    starve_cnt_d  = starve_cnt_q;
    inst_starved  = inst_req_i && (starve_cnt_q == LIMIT);
    if (arb_en_i) begin
      if (data_req_i && !inst_starved) begin
        grant_vld_c_o = 1'b1;
        grant_own_c_o = DATA;
        // Only data grants that make inst wait count toward starvation.
        if (inst_req_i && (starve_cnt_q < LIMIT)) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end else if (inst_req_i) begin
        grant_vld_c_o = 1'b1;
        grant_own_c_o = INST;
        starve_cnt_d  = '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and load/store,
// running one addr_ok/data_ok transaction at a time and acking the owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ack,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [WEN_W-1:0]  data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic [WEN_W-1:0]  mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_for_mem
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  mem_bus_req_t      bus_q, bus_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_ack_q, inst_ack_d;
  logic              data_ack_q, data_ack_d;
  logic              grant_vld_c;
  owner_e            grant_own_c;

  mem_grant_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant_sel (
    .clk           (clk),
    .rst           (rst),
    .arb_en_i      (state_q == IDLE),
    .inst_req_i    (inst_req),
    .data_req_i    (data_req),
    .grant_vld_c_o (grant_vld_c),
    .grant_own_c_o (grant_own_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= INST;
      bus_q        <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      bus_q        <= bus_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    bus_d        = bus_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          owner_d = grant_own_c;
          state_d = ADDR;
          if (grant_own_c == DATA) begin
            bus_d = '{req: 1'b1, wen: data_wen, addr: data_addr, wdata: data_wdata};
          end else begin
            bus_d = '{req: 1'b1, wen: '0, addr: inst_addr, wdata: '0};
          end
        end
      end
      ADDR: begin
        if (mem_addr_ok) begin
          bus_d.req = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // The ack is registered here so it lands exactly in RESP.
        if (mem_data_ok) begin
          state_d = RESP;
          if (owner_q == DATA) begin
            data_ack_d = 1'b1;
            if (bus_q.wen == '0) begin
              data_rdata_d = mem_rdata;
            end
          end else begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req    = bus_q.req;
  assign mem_wen    = bus_q.wen;
  assign mem_addr   = bus_q.addr;
  assign mem_wdata  = bus_q.wdata;
  assign inst_ack   = inst_ack_q;
  assign data_ack   = data_ack_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  assign stall_for_mem = (inst_req & ~inst_ack) | (data_req & ~data_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter built with STARVE_LIMIT=2.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall_for_mem;

  int n_total = 0;
  int n_pass  = 0;

  int          s_ack_cyc;
  logic        s_ack_data;
  int          s_n_acks;
  int          s_req_cyc;
  logic        s_stable;
  logic [3:0]  s_wen;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_ack      (inst_ack),
    .inst_rdata    (inst_rdata),
    .data_req      (data_req),
    .data_wen      (data_wen),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_ack      (data_ack),
    .data_rdata    (data_rdata),
    .mem_req       (mem_req),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_addr_ok   (mem_addr_ok),
    .mem_data_ok   (mem_data_ok),
    .mem_rdata     (mem_rdata),
    .stall_for_mem (stall_for_mem)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bus responder: addr_ok after aok_dly request cycles, data_ok after dok_dly
  // wait cycles; drops the acked requester's req and records what it saw.
  task automatic serve(input int aok_dly, input int dok_dly, input logic [31:0] rd,
                       output int ack_cyc, output logic ack_is_data, output int n_acks,
                       output int req_cyc, output logic stable, output logic [3:0] f_wen,
                       output logic [31:0] f_addr, output logic [31:0] f_wdata);
    int   wait_cnt = 0;
    int   after = 0;
    logic accepted = 1'b0;
    logic delivered = 1'b0;
    ack_cyc = -1; ack_is_data = 1'b0; n_acks = 0; req_cyc = 0; stable = 1'b1;
    f_wen = '0; f_addr = '0; f_wdata = '0;
    for (int c = 0; c < 60; c++) begin
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (mem_req) begin
        if (req_cyc == 0) begin
          f_wen = mem_wen; f_addr = mem_addr; f_wdata = mem_wdata;
        end else if (mem_wen !== f_wen || mem_addr !== f_addr || mem_wdata !== f_wdata) begin
          stable = 1'b0;
        end
        if (req_cyc == aok_dly) begin
          mem_addr_ok = 1'b1;
          accepted    = 1'b1;
        end
        req_cyc++;
      end else if (accepted && !delivered) begin
        if (wait_cnt == dok_dly) begin
          mem_data_ok = 1'b1;
          mem_rdata   = rd;
          delivered   = 1'b1;
        end
        wait_cnt++;
      end
      if (inst_ack || data_ack) begin
        n_acks++;
        if (ack_cyc < 0) begin
          ack_cyc     = c;
          ack_is_data = data_ack;
        end
        if (inst_ack) inst_req = 1'b0;
        if (data_ack) data_req = 1'b0;
      end
      if (ack_cyc >= 0) begin
        after++;
        if (after > 3) break;
      end
      tick();
    end
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    n_total++;
    if ({inst_ack, data_ack, mem_req, mem_wen, mem_addr, mem_wdata, inst_rdata, data_rdata} !== '0)
      $display("FAIL reset_outputs: got ack=%b/%b req=%b addr=%h irdata=%h drdata=%h want all 0",
               inst_ack, data_ack, mem_req, mem_addr, inst_rdata, data_rdata);
    else n_pass++;
    n_total++;
    if (stall_for_mem !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_for_mem);
    else n_pass++;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_inst_read;
    inst_addr = 32'hBFC0_0000;
    inst_req  = 1'b1;
    #1;
    n_total++;
    if (stall_for_mem !== 1'b1) $display("FAIL ird_stall_c0: got %b want 1", stall_for_mem);
    else n_pass++;
    tick();
    n_total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0000 || mem_wen !== 4'h0)
      $display("FAIL ird_bus_c1: got req=%b addr=%h wen=%h want 1/bfc00000/0", mem_req, mem_addr, mem_wen);
    else n_pass++;
    n_total++;
    if (stall_for_mem !== 1'b1) $display("FAIL ird_stall_c1: got %b want 1", stall_for_mem);
    else n_pass++;
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    n_total++;
    if (mem_req !== 1'b0 || inst_ack !== 1'b0 || stall_for_mem !== 1'b1)
      $display("FAIL ird_c2: got req=%b ack=%b stall=%b want 0/0/1", mem_req, inst_ack, stall_for_mem);
    else n_pass++;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h3C01_0001;
    tick();
    mem_data_ok = 1'b0;
    n_total++;
    if (inst_ack !== 1'b1 || inst_rdata !== 32'h3C01_0001)
      $display("FAIL ird_ack_c3: got ack=%b rdata=%h want 1/3c010001", inst_ack, inst_rdata);
    else n_pass++;
    n_total++;
    if (stall_for_mem !== 1'b0) $display("FAIL ird_stall_c3: got %b want 0", stall_for_mem);
    else n_pass++;
    inst_req = 1'b0;
    tick();
    n_total++;
    if (inst_ack !== 1'b0 || stall_for_mem !== 1'b0)
      $display("FAIL ird_c4: got ack=%b stall=%b want 0/0", inst_ack, stall_for_mem);
    else n_pass++;
  endtask

  task automatic test_data_read;
    data_wen  = 4'h0;
    data_addr = 32'h8000_0020;
    data_req  = 1'b1;
    serve(0, 0, 32'h55AA_1234, s_ack_cyc, s_ack_data, s_n_acks, s_req_cyc, s_stable, s_wen, s_addr, s_wdata);
    n_total++;
    if (s_ack_cyc !== 3 || s_ack_data !== 1'b1 || s_n_acks !== 1)
      $display("FAIL drd_ack: got cyc=%0d data=%b n=%0d want 3/1/1", s_ack_cyc, s_ack_data, s_n_acks);
    else n_pass++;
    n_total++;
    if (data_rdata !== 32'h55AA_1234 || s_addr !== 32'h8000_0020 || s_wen !== 4'h0)
      $display("FAIL drd_data: got rdata=%h addr=%h wen=%h want 55aa1234/80000020/0", data_rdata, s_addr, s_wen);
    else n_pass++;
    tick();
  endtask

  task automatic test_data_write;
    data_wen   = 4'b0011;
    data_addr  = 32'h8000_0010;
    data_wdata = 32'h1234_ABCD;
    data_req   = 1'b1;
    serve(1, 0, 32'hDEAD_BEEF, s_ack_cyc, s_ack_data, s_n_acks, s_req_cyc, s_stable, s_wen, s_addr, s_wdata);
    n_total++;
    if (s_wen !== 4'b0011 || s_addr !== 32'h8000_0010 || s_wdata !== 32'h1234_ABCD || s_stable !== 1'b1)
      $display("FAIL dwr_bus: got wen=%b addr=%h wdata=%h stable=%b want 0011/80000010/1234abcd/1",
               s_wen, s_addr, s_wdata, s_stable);
    else n_pass++;
    n_total++;
    if (s_ack_cyc !== 4 || s_ack_data !== 1'b1 || s_n_acks !== 1)
      $display("FAIL dwr_ack: got cyc=%0d data=%b n=%0d want 4/1/1", s_ack_cyc, s_ack_data, s_n_acks);
    else n_pass++;
    n_total++;
    if (data_rdata !== 32'h55AA_1234) $display("FAIL dwr_rdata_kept: got %h want 55aa1234", data_rdata);
    else n_pass++;
    data_wen = 4'h0;
    tick();
  endtask

  task automatic test_backpressure;
    inst_addr = 32'hBFC0_0100;
    inst_req  = 1'b1;
    serve(3, 4, 32'h2402_0005, s_ack_cyc, s_ack_data, s_n_acks, s_req_cyc, s_stable, s_wen, s_addr, s_wdata);
    n_total++;
    if (s_req_cyc !== 4 || s_stable !== 1'b1 || s_addr !== 32'hBFC0_0100)
      $display("FAIL bp_req: got cycles=%0d stable=%b addr=%h want 4/1/bfc00100", s_req_cyc, s_stable, s_addr);
    else n_pass++;
    n_total++;
    if (s_ack_cyc !== 10 || s_ack_data !== 1'b0 || s_n_acks !== 1)
      $display("FAIL bp_ack: got cyc=%0d data=%b n=%0d want 10/0/1", s_ack_cyc, s_ack_data, s_n_acks);
    else n_pass++;
    n_total++;
    if (inst_rdata !== 32'h2402_0005) $display("FAIL bp_rdata: got %h want 24020005", inst_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_starve;
    logic got [6];
    logic exp_own [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int   n = 0;
    logic both = 1'b0;
    inst_addr   = 32'hBFC0_0400;
    data_addr   = 32'h8000_0400;
    data_wen    = 4'h0;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_0777;
    inst_req    = 1'b1;
    data_req    = 1'b1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (inst_ack && data_ack) both = 1'b1;
      if (inst_ack || data_ack) begin
        got[n] = data_ack;
        n++;
      end
      if (n == 6) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
      tick();
    end
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    n_total++;
    if (n !== 6 || both !== 1'b0) $display("FAIL starve_count: got acks=%0d both=%b want 6/0", n, both);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        n_total++;
        if (got[i] !== exp_own[i]) $display("FAIL starve_order[%0d]: got owner %b want %b", i, got[i], exp_own[i]);
        else n_pass++;
      end
    end
    tick(); tick();
  endtask

  task automatic test_drop;
    inst_addr = 32'hBFC0_0200;
    data_addr = 32'h8000_0040;
    data_wen  = 4'h0;
    inst_req  = 1'b1;
    tick();
    n_total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0200)
      $display("FAIL drop_grant: got req=%b addr=%h want 1/bfc00200", mem_req, mem_addr);
    else n_pass++;
    inst_req = 1'b0;
    data_req = 1'b1;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hCAFE_F00D;
    tick();
    mem_data_ok = 1'b0;
    n_total++;
    if (inst_ack !== 1'b1 || data_ack !== 1'b0 || inst_rdata !== 32'hCAFE_F00D)
      $display("FAIL drop_ack: got iack=%b dack=%b rdata=%h want 1/0/cafef00d", inst_ack, data_ack, inst_rdata);
    else n_pass++;
    tick();
    n_total++;
    if (inst_ack !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL drop_idle: got iack=%b req=%b want 0/0", inst_ack, mem_req);
    else n_pass++;
    tick();
    n_total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0040)
      $display("FAIL drop_next_grant: got req=%b addr=%h want 1/80000040", mem_req, mem_addr);
    else n_pass++;
    serve(0, 0, 32'h0BAD_F00D, s_ack_cyc, s_ack_data, s_n_acks, s_req_cyc, s_stable, s_wen, s_addr, s_wdata);
    n_total++;
    if (s_ack_data !== 1'b1 || s_n_acks !== 1 || data_rdata !== 32'h0BAD_F00D)
      $display("FAIL drop_data_done: got data=%b n=%0d rdata=%h want 1/1/0badf00d", s_ack_data, s_n_acks, data_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_mid_reset;
    logic bad = 1'b0;
    inst_addr = 32'hBFC0_0300;
    inst_req  = 1'b1;
    tick();
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    n_total++;
    if (mem_addr !== 32'hBFC0_0300 || mem_req !== 1'b0)
      $display("FAIL mrst_in_wait: got addr=%h req=%b want bfc00300/0", mem_addr, mem_req);
    else n_pass++;
    rst      = 1'b0;
    inst_req = 1'b0;
    #2;
    n_total++;
    if ({inst_ack, data_ack, mem_req, mem_wen, mem_addr, mem_wdata, inst_rdata, data_rdata} !== '0)
      $display("FAIL mrst_async: got ack=%b/%b req=%b addr=%h irdata=%h drdata=%h want all 0",
               inst_ack, data_ack, mem_req, mem_addr, inst_rdata, data_rdata);
    else n_pass++;
    n_total++;
    if (stall_for_mem !== 1'b0) $display("FAIL mrst_stall: got %b want 0", stall_for_mem);
    else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1111_1111;
    tick();
    mem_data_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (inst_ack || data_ack || mem_req || inst_rdata !== 32'h0) bad = 1'b1;
      tick();
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL mrst_late_data_ok: got spurious activity=%b want 0", bad);
    else n_pass++;
    inst_addr = 32'hBFC0_0380;
    inst_req  = 1'b1;
    serve(0, 0, 32'h3C1D_0000, s_ack_cyc, s_ack_data, s_n_acks, s_req_cyc, s_stable, s_wen, s_addr, s_wdata);
    n_total++;
    if (s_ack_cyc !== 3 || s_n_acks !== 1 || inst_rdata !== 32'h3C1D_0000)
      $display("FAIL mrst_recover: got cyc=%0d n=%0d rdata=%h want 3/1/3c1d0000", s_ack_cyc, s_n_acks, inst_rdata);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_data_read();
    test_data_write();
    test_backpressure();
    test_starve();
    test_drop();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
